qracc_ofmap_writeback_queue: RTL and testbench
==============================================

// Module: qracc_ofmap_writeback_queue
// PURPOSE
// - Buffers output-pixel vectors produced by the QRAcc array/output scaler and drains them into the
//   activation buffer's internal write port as internalInterfaceWidth-wide beats.
// - Sits between the array output stage and the activation buffer.
// - Absorbs activation-buffer write backpressure.
// - Tells the compute controller when every result has landed (drives int_write_queue_valid).
// PARAMETERS
// numOutputs                 256  output channels per pixel vector (one byte each)
// internalInterfaceWidth     128  activation-buffer internal write width, bits
// queueDepth                 4    pixel-vector entries held; power of 2, >=2
// addrWidth                  32   activation-buffer address width
// internalInterfaceElements  -    localparam, internalInterfaceWidth/8
// maxBeats                   -    localparam, numOutputs/internalInterfaceElements
// PORTS
// clk           in   1                              clock
// nrst          in   1                              async active-low reset
// clear         in   1                              sync clear (csr_main_clear)
// num_out_ch    in   10                             cfg.num_output_channels; valid range 1..numOutputs
// in_valid      in   1                              pixel vector valid (qracc_output_valid)
// in_ready      out  1                              queue can accept
// in_data       in   numOutputs*8                   byte k = output channel k
// in_addr       in   addrWidth                      ofmap base address of this pixel vector
// wr_en         out  1                              beat valid to activation buffer
// wr_ready      in   1                              buffer accepts beat
// wr_addr       out  addrWidth                      beat address
// wr_data       out  internalInterfaceWidth         beat payload
// wr_mask       out  internalInterfaceElements      per-byte write enable
// queue_idle    out  1                              queue empty and no beat pending (int_write_queue_valid)
// BEHAVIOUR
// - Reset and clear: FIFO empty, beat_ctr=0, state S_IDLE.
//   Outputs: wr_en=0, wr_addr=0, wr_data=0, wr_mask=0, in_ready=1, queue_idle=1.
//   clear mid-drain drops all entries and any partial beat in the same edge.
// - Push: in_valid && in_ready stores {in_addr, in_data}.
//   in_ready = !full, registered-count based; there is no full-with-pop bypass.
// - Beats per entry: nbeats = ceil(num_out_ch / internalInterfaceElements), range 1..maxBeats.
//   num_out_ch is sampled per entry at the entry's first beat.
// - FSM:
//   S_IDLE  -> S_DRAIN when FIFO not empty.
//   S_DRAIN: wr_en=1, wr_addr = head.addr + beat_ctr*internalInterfaceElements,
//            wr_data = head.data[beat_ctr*internalInterfaceWidth +: internalInterfaceWidth].
//   - On wr_en && wr_ready with beat_ctr < nbeats-1: beat_ctr++.
//   - On wr_en && wr_ready with beat_ctr == nbeats-1: pop head, beat_ctr=0.
//     Stay in S_DRAIN if another entry remains after the pop, else go to S_IDLE.
// - wr_mask: all ones, except on the last beat, where only the low
//   (num_out_ch - (nbeats-1)*internalInterfaceElements) bits are set.
// - While wr_ready=0: wr_en, wr_addr, wr_data and wr_mask hold stable (AXI-style valid hold).
// - Latency: an entry pushed at edge t drives wr_en from the cycle after t.
//   With wr_ready held high, an entry costs nbeats cycles and back-to-back entries have no bubble.
// - Simultaneous push and pop (not full): count unchanged, both take effect.
//   Push into an empty FIFO while in S_IDLE: entry is visible next cycle.
// - Pointers: wr_ptr and rd_ptr wrap modulo queueDepth.
//   count is $clog2(queueDepth)+1 bits; full when count==queueDepth.
// - queue_idle = (count==0) && (state==S_IDLE). It is combinational from registers only.
// - Address arithmetic is addrWidth bits, unsigned, and wraps silently.
// STRUCTURE
// - qracc_pkg: add typedef wbq_entry_t {addr, data}.
// - Sub-module qracc_sync_fifo (params WIDTH, DEPTH): push/pop, full/empty/count, async nrst, sync clear.
// - Top module: drain FSM, beat counter, mask/address generation.
// TESTING
// 1. num_out_ch=32, 1 push addr=0x100, wr_ready=1
//    -> beats at 0x100 and 0x110, mask 0xFFFF both, queue_idle=1 on the 3rd cycle.
// 2. num_out_ch=20, push addr=0x40
//    -> beats at 0x40 (mask 0xFFFF) and 0x50 (mask 0x000F); data bytes 16..19 in the low lanes.
// 3. wr_ready=0, then 5 pushes
//    -> in_ready=0 after the 4th push; the 5th stalls.
//    -> wr_en/wr_addr/wr_data stable throughout the stall.
//    -> release wr_ready: all 4 entries drain in order, then the 5th is accepted.
// 4. num_out_ch=256, wr_ready toggling 1/0 every cycle
//    -> 16 beats per entry at addrs base+0..base+0xF0, no beat dropped or duplicated.
// 5. Assert clear mid-drain with 3 entries queued
//    -> next cycle wr_en=0, queue_idle=1, in_ready=1.
//    -> a subsequent push drains from beat 0.
// 6. nrst low mid-drain
//    -> all outputs at reset values immediately (async).
//    -> after release, a push with num_out_ch=16 gives a single beat with mask 0xFFFF.

Source files
------------

// File: rtl/qracc_pkg.sv
// Shared types and default sizing for the QRAcc output writeback path.
package qracc_pkg;

  localparam int QRACC_NUM_OUTPUTS = 256;  // output channels per pixel vector
  localparam int QRACC_IIF_WIDTH   = 128;  // activation-buffer internal write width
  localparam int QRACC_QUEUE_DEPTH = 4;    // pixel vectors held by the writeback queue
  localparam int QRACC_ADDR_WIDTH  = 32;   // activation-buffer address width
  localparam int QRACC_CH_WIDTH    = 10;   // width of the output-channel count field

  // One queued pixel vector: its ofmap base address and one byte per channel.
  typedef struct packed {
    logic [QRACC_ADDR_WIDTH-1:0]    addr;
    logic [QRACC_NUM_OUTPUTS*8-1:0] data;
  } wbq_entry_t;

  // Drain FSM states.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } wbq_state_t;

endpackage

// File: rtl/qracc_sync_fifo.sv
// Single-clock FIFO with registered occupancy count, async reset and sync clear.
// Pointers wrap modulo DEPTH (DEPTH is a power of two).
module qracc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Overflow and underflow requests are ignored rather than corrupting state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the data array is deliberately not reset; occupancy is tracked by
  // count/pointers, so stale contents are never observed and the array can
  // map onto plain flops or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/qracc_ofmap_writeback_queue.sv
// Buffers output-pixel vectors from the QRAcc output stage and drains each one
// into the activation buffer's internal write port as a run of wide beats.
// queue_idle tells the compute controller every result has landed.
module qracc_ofmap_writeback_queue
  import qracc_pkg::*;
#(
  parameter int numOutputs             = QRACC_NUM_OUTPUTS,
  parameter int internalInterfaceWidth = QRACC_IIF_WIDTH,
  parameter int queueDepth             = QRACC_QUEUE_DEPTH,
  parameter int addrWidth              = QRACC_ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                clear,
  input  logic [QRACC_CH_WIDTH-1:0]           num_out_ch,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [numOutputs*8-1:0]             in_data,
  input  logic [addrWidth-1:0]                in_addr,
  output logic                                wr_en,
  input  logic                                wr_ready,
  output logic [addrWidth-1:0]                wr_addr,
  output logic [internalInterfaceWidth-1:0]   wr_data,
  output logic [internalInterfaceWidth/8-1:0] wr_mask,
  output logic                                queue_idle
);

  localparam int ELEMS      = internalInterfaceWidth / 8;
  localparam int MAX_BEATS  = numOutputs / ELEMS;
  localparam int ELEM_SHIFT = $clog2(ELEMS);
  localparam int CNT_W      = $clog2(queueDepth) + 1;
  localparam int BIDX_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int BCNT_W     = $clog2(MAX_BEATS + 1);
  localparam int REM_W      = $clog2(ELEMS + 1);
  localparam int CH_W       = QRACC_CH_WIDTH;

  wbq_state_t        state;
  wbq_state_t        next_state;
  wbq_entry_t        push_entry;
  wbq_entry_t        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic              push_fire;
  logic              beat_fire;
  logic              pop_fire;
  logic              last_beat;

  logic [BIDX_W-1:0] beat_ctr;
  logic [BCNT_W-1:0] nbeats_q;     // beat count latched at the head entry's first beat
  logic [REM_W-1:0]  rem_q;        // valid bytes in the last beat, latched likewise
  logic [CH_W-1:0]   eff_ch;
  logic [BCNT_W-1:0] live_nbeats;
  logic [REM_W-1:0]  live_rem;
  logic [BCNT_W-1:0] cur_nbeats;
  logic [REM_W-1:0]  cur_rem;

  // in_ready comes from the registered count only: a full queue does not
  // accept even when the head is leaving on the same edge.
  assign in_ready   = !fifo_full;
  assign push_fire  = in_valid && in_ready;
  assign beat_fire  = wr_en && wr_ready;
  assign pop_fire   = beat_fire && last_beat;
  assign queue_idle = (fifo_count == '0) && (state == S_IDLE);

  assign push_entry.addr = in_addr;
  assign push_entry.data = in_data;

  qracc_sync_fifo #(
    .WIDTH ($bits(wbq_entry_t)),
    .DEPTH (queueDepth)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .clear (clear),
    .push  (push_fire),
    .pop   (pop_fire),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Beat geometry from the live channel count. Out-of-range counts are
  // clamped to 1..numOutputs so the mask is never empty and beats never
  // index past the pixel vector.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise an uncovered path would infer a latch.
    eff_ch = num_out_ch;
    if (num_out_ch == '0) begin
      eff_ch = CH_W'(1);
    end else if (num_out_ch > CH_W'(numOutputs)) begin
      eff_ch = CH_W'(numOutputs);
    end
    live_nbeats = BCNT_W'((eff_ch + CH_W'(ELEMS - 1)) >> ELEM_SHIFT);
    live_rem    = REM_W'(eff_ch - (CH_W'(live_nbeats - 1'b1) << ELEM_SHIFT));
  end

  // The channel count is taken live on an entry's first beat and from the
  // latched copy afterwards, so a mid-entry change cannot reshape it.
  always_comb begin
    cur_nbeats = nbeats_q;
    cur_rem    = rem_q;
    if (beat_ctr == '0) begin
      cur_nbeats = live_nbeats;
      cur_rem    = live_rem;
    end
    last_beat = (BCNT_W'(beat_ctr) == (cur_nbeats - 1'b1));
  end

  // Beat counter and per-entry geometry latch.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      beat_ctr <= '0;
      nbeats_q <= '0;
      rem_q    <= '0;
    end else if (clear) begin
      beat_ctr <= '0;
      nbeats_q <= '0;
      rem_q    <= '0;
    end else if (beat_fire) begin
      if (beat_ctr == '0) begin
        nbeats_q <= live_nbeats;
        rem_q    <= live_rem;
      end
      if (last_beat) beat_ctr <= '0;
      else           beat_ctr <= beat_ctr + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= next_state;
  end

  // FSM next state: entering on the push edge makes a new entry drive wr_en
  // in the very next cycle; leaving only when the last entry pops with
  // nothing arriving keeps back-to-back entries bubble-free.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (push_fire || !fifo_empty) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop_fire && (fifo_count == CNT_W'(1)) && !push_fire) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (clear) next_state = S_IDLE;
  end

  // FSM outputs: write-port signals are functions of registered state, so
  // they hold steady while wr_ready is low and drop to zero when idle.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_mask = '0;
    if (state == S_DRAIN) begin
      wr_en   = 1'b1;
      wr_addr = head.addr + (addrWidth'(beat_ctr) << ELEM_SHIFT);
      wr_data = head.data[int'(beat_ctr)*internalInterfaceWidth +: internalInterfaceWidth];
      for (int i = 0; i < ELEMS; i++) begin
        wr_mask[i] = !last_beat || (i < int'(cur_rem));
      end
    end
  end

endmodule

// File: tb/tb_qracc_ofmap_writeback_queue.sv
// Directed, table-driven bench for qracc_ofmap_writeback_queue.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_qracc_ofmap_writeback_queue;

  localparam int NO = 256;
  localparam int IW = 128;
  localparam int EL = IW / 8;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            nrst;
  logic            clear;
  logic [9:0]      num_out_ch;
  logic            in_valid;
  logic            in_ready;
  logic [NO*8-1:0] in_data;
  logic [AW-1:0]   in_addr;
  logic            wr_en;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [IW-1:0]   wr_data;
  logic [EL-1:0]   wr_mask;
  logic            queue_idle;

  int checks   = 0;
  int failures = 0;
  bit toggle_phase = 1'b0;

  always #5 clk = ~clk;

  qracc_ofmap_writeback_queue dut (
    .clk        (clk),
    .nrst       (nrst),
    .clear      (clear),
    .num_out_ch (num_out_ch),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .queue_idle (queue_idle)
  );

  typedef struct {
    logic [9:0]  ch;
    logic [31:0] addr;
    logic [7:0]  seed;
    int          nbeats;
    logic [15:0] last_mask;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // Pixel vector whose byte k is k+seed.
  function automatic logic [NO*8-1:0] pattern(input logic [7:0] seed);
    logic [NO*8-1:0] p;
    for (int k = 0; k < NO; k++) p[k*8 +: 8] = 8'(k) + seed;
    return p;
  endfunction

  function automatic logic [IW-1:0] slice(input logic [7:0] seed, input int b);
    logic [NO*8-1:0] p;
    p = pattern(seed);
    return p[b*IW +: IW];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},      wr_en,      1'b0);
    check({tag, "_wr_addr"},    wr_addr,    '0);
    check({tag, "_wr_data"},    wr_data,    '0);
    check({tag, "_wr_mask"},    wr_mask,    '0);
    check({tag, "_in_ready"},   in_ready,   1'b1);
    check({tag, "_queue_idle"}, queue_idle, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_wr_en"},      wr_en,      1'b0);
    check({tag, "_idle_queue_idle"}, queue_idle, 1'b1);
  endtask

  // Present one entry; waits (bounded) for in_ready. Returns at the falling
  // edge after the accepting rising edge.
  task automatic push(input logic [31:0] a, input logic [7:0] s);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = pattern(s);
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) timeout("push");
  endtask

  // Wait (bounded) for one beat to be accepted. Every cycle wr_en is high the
  // outputs must equal this beat, which also proves they hold during stalls.
  task automatic expect_beat(input logic [31:0] ea, input logic [IW-1:0] ed,
                             input logic [15:0] em, input bit toggle);
    bit done;
    bit rdy;
    done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      rdy = toggle ? toggle_phase : 1'b1;
      if (toggle) toggle_phase = !toggle_phase;
      if (wr_en) begin
        check("beat_addr", wr_addr, ea);
        check("beat_data", wr_data, ed);
        check("beat_mask", wr_mask, em);
        if (rdy) done = 1'b1;
      end
      wr_ready = rdy;
      @(negedge clk);
    end
    if (!done) timeout("beat");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-computed vectors: nbeats = ceil(ch/16), last mask = low (ch-(nbeats-1)*16) bits.
    vecs[0] = '{ch: 10'd32,  addr: 32'h0000_0100, seed: 8'h00, nbeats: 2,  last_mask: 16'hFFFF};
    vecs[1] = '{ch: 10'd20,  addr: 32'h0000_0040, seed: 8'h11, nbeats: 2,  last_mask: 16'h000F};
    vecs[2] = '{ch: 10'd16,  addr: 32'h0000_0200, seed: 8'h22, nbeats: 1,  last_mask: 16'hFFFF};
    vecs[3] = '{ch: 10'd1,   addr: 32'h0000_0300, seed: 8'h33, nbeats: 1,  last_mask: 16'h0001};
    vecs[4] = '{ch: 10'd17,  addr: 32'h0000_1000, seed: 8'h44, nbeats: 2,  last_mask: 16'h0001};
    vecs[5] = '{ch: 10'd255, addr: 32'hFFFF_FFF0, seed: 8'h55, nbeats: 16, last_mask: 16'h7FFF};
    vecs[6] = '{ch: 10'd100, addr: 32'h0000_0500, seed: 8'h66, nbeats: 7,  last_mask: 16'h000F};

    nrst       = 1'b0;
    clear      = 1'b0;
    num_out_ch = 10'd32;
    in_valid   = 1'b0;
    in_addr    = '0;
    in_data    = '0;
    wr_ready   = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    nrst = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Single entries with wr_ready high: latency, addresses, data, masks.
    for (int v = 0; v < 7; v++) begin
      num_out_ch = vecs[v].ch;
      wr_ready   = 1'b1;
      push(vecs[v].addr, vecs[v].seed);
      check("first_beat_latency", wr_en, 1'b1);
      for (int b = 0; b < vecs[v].nbeats; b++) begin
        expect_beat(vecs[v].addr + 32'(b * EL), slice(vecs[v].seed, b),
                    (b == vecs[v].nbeats - 1) ? vecs[v].last_mask : 16'hFFFF, 1'b0);
      end
      check_idle("vec");
    end

    // Backpressure: fill the queue, stall a fifth push, then drain in order.
    num_out_ch = 10'd32;
    wr_ready   = 1'b0;
    for (int e = 0; e < 4; e++) push(32'h1000 + 32'(e * 256), 8'(8'h30 + e));
    check("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_addr  = 32'h1400;
    in_data  = pattern(8'h34);
    for (int i = 0; i < 4; i++) begin
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_wr_en",    wr_en,    1'b1);
      check("stall_wr_addr",  wr_addr,  32'h1000);
      check("stall_wr_data",  wr_data,  slice(8'h30, 0));
      @(negedge clk);
    end
    fork
      begin : acceptor
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
          if (in_ready) begin
            seen = 1'b1;
            // The head must already be the second entry: no bypass on a full pop.
            check("fifth_accept_point", wr_addr, 32'h1100);
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
        if (!seen) timeout("fifth_accept");
      end
      begin : drainer
        for (int e = 0; e < 5; e++) begin
          for (int b = 0; b < 2; b++) begin
            expect_beat(32'h1000 + 32'(e * 256) + 32'(b * EL), slice(8'(8'h30 + e), b),
                        16'hFFFF, 1'b0);
          end
        end
      end
    join
    check_idle("backpressure");

    // Full-width entries with wr_ready toggling every cycle.
    num_out_ch   = 10'd256;
    wr_ready     = 1'b0;
    push(32'h2000, 8'h50);
    push(32'h3000, 8'h60);
    toggle_phase = 1'b0;
    for (int e = 0; e < 2; e++) begin
      for (int b = 0; b < 16; b++) begin
        expect_beat((e == 0 ? 32'h2000 : 32'h3000) + 32'(b * EL),
                    slice(e == 0 ? 8'h50 : 8'h60, b), 16'hFFFF, 1'b1);
      end
    end
    wr_ready = 1'b1;
    check_idle("toggle");

    // Synchronous clear mid-drain with three entries queued.
    num_out_ch = 10'd32;
    wr_ready   = 1'b0;
    push(32'h0A00, 8'h80);
    push(32'h0B00, 8'h81);
    push(32'h0C00, 8'h82);
    expect_beat(32'h0A00, slice(8'h80, 0), 16'hFFFF, 1'b0);
    wr_ready = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_wr_en",      wr_en,      1'b0);
    check("clear_queue_idle", queue_idle, 1'b1);
    check("clear_in_ready",   in_ready,   1'b1);
    wr_ready = 1'b1;
    push(32'h0D00, 8'h90);
    expect_beat(32'h0D00, slice(8'h90, 0), 16'hFFFF, 1'b0);
    expect_beat(32'h0D10, slice(8'h90, 1), 16'hFFFF, 1'b0);
    check_idle("after_clear");

    // Asynchronous reset mid-drain.
    num_out_ch = 10'd32;
    wr_ready   = 1'b0;
    push(32'h0900, 8'h70);
    push(32'h0980, 8'h71);
    expect_beat(32'h0900, slice(8'h70, 0), 16'hFFFF, 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    nrst       = 1'b1;
    num_out_ch = 10'd16;
    wr_ready   = 1'b1;
    @(negedge clk);
    push(32'h0800, 8'h72);
    expect_beat(32'h0800, slice(8'h72, 0), 16'hFFFF, 1'b0);
    check_idle("after_reset_push");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
